complex_axpy_sequencer: RTL

Sequencer that drives the 8-lane complex multiply-add datapath (`result = y ± c·x`) over a full vector of NOE complex elements. It fetches x and y vector chunks of NI lanes from a dual-read vector memory, presents them to the datapath, and tracks each chunk through the fixed pipeline latency. It writes results back with a lane mask and signals completion. It replaces the free-running finish counter with exact per-chunk valid tracking.

---
 rtl/complex_axpy_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/complex_axpy_sequencer.sv
// Chunked sequencer for the 8-lane complex y +/- c*x datapath: issues reads, tracks each
// chunk through the datapath latency, writes back with lane masks. Option: CAXPY_ZERO_PAD_EN.
module complex_axpy_sequencer #(
   parameter int NOE           = 19,
   parameter int NI            = 8,
   parameter int ELEMENT_WIDTH = 64,
   parameter int PIPE_LATENCY  = 8,
   parameter int ADDR_WIDTH    = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic                        op_in,
   input  logic [ELEMENT_WIDTH-1:0]    constant_in,
   output logic                        busy,
   output logic                        done,
   output logic                        rd_en,
   output logic [ADDR_WIDTH-1:0]       rd_addr,
   input  logic [ELEMENT_WIDTH*NI-1:0] x_rd_data,
   input  logic [ELEMENT_WIDTH*NI-1:0] y_rd_data,
   output logic [ELEMENT_WIDTH*NI-1:0] dp_first_row,
   output logic [ELEMENT_WIDTH*NI-1:0] dp_second_row,
   output logic [ELEMENT_WIDTH-1:0]    dp_constant,
   output logic                        dp_op,
   input  logic [ELEMENT_WIDTH*NI-1:0] dp_result,
   output logic                        wr_en,
   output logic [ADDR_WIDTH-1:0]       wr_addr,
   output logic [ELEMENT_WIDTH*NI-1:0] wr_data,
   output logic [NI-1:0]               wr_mask
);

   localparam int CHUNKS = (NOE + NI - 1) / NI;
   localparam int REM    = NOE % NI;

   function automatic logic [NI-1:0] last_mask_f();
      logic [NI-1:0] m;
      m = '0;
      for (int j = 0; j < NI; j++)
         if (REM == 0 || j < REM) m[j] = 1'b1;
      return m;
   endfunction

   localparam logic [NI-1:0] LAST_MASK = last_mask_f();

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t                  state, state_nxt;
   logic [ADDR_WIDTH-1:0]   issue_cnt;
   logic                    issue_last;
   logic [PIPE_LATENCY:0]   vld_pipe;
   logic [PIPE_LATENCY:0]   last_pipe;
   logic [ADDR_WIDTH-1:0]   idx_pipe [PIPE_LATENCY:0];
   logic                    op_q;
   logic [ELEMENT_WIDTH-1:0] const_q;

   assign issue_last = (issue_cnt == ADDR_WIDTH'(CHUNKS - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         issue_cnt <= '0;
         vld_pipe  <= '0;
         last_pipe <= '0;
         op_q      <= 1'b0;
         const_q   <= '0;
         for (int s = 0; s <= PIPE_LATENCY; s++) idx_pipe[s] <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && start) begin
            op_q    <= op_in;
            const_q <= constant_in;
         end
         if (rd_en) issue_cnt <= issue_last ? '0 : issue_cnt + 1'b1;
         // stage 0 lines up with the memory data returned the cycle after rd_en
         vld_pipe[0]  <= rd_en;
         last_pipe[0] <= rd_en & issue_last;
         idx_pipe[0]  <= rd_en ? issue_cnt : '0;
         for (int s = 1; s <= PIPE_LATENCY; s++) begin
            vld_pipe[s]  <= vld_pipe[s-1];
            last_pipe[s] <= last_pipe[s-1];
            idx_pipe[s]  <= idx_pipe[s-1];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      rd_en     = 1'b0;
      unique case (state)
         S_IDLE:  if (start) state_nxt = S_ISSUE;
         S_ISSUE: begin
            busy  = 1'b1;
            rd_en = 1'b1;
            if (issue_last) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            busy = 1'b1;
            if (vld_pipe[PIPE_LATENCY] && last_pipe[PIPE_LATENCY]) state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign rd_addr     = issue_cnt;
   assign dp_op       = op_q;
   assign dp_constant = const_q;

   genvar j;
   generate
      for (j = 0; j < NI; j++) begin : g_lane
`ifdef CAXPY_ZERO_PAD_EN
         // lanes past the end of the vector on the final chunk are fed as zero
         logic pad;
         assign pad = vld_pipe[0] & last_pipe[0] & ~LAST_MASK[j];
         assign dp_first_row [ELEMENT_WIDTH*(NI-j)-1 -: ELEMENT_WIDTH] =
            pad ? '0 : x_rd_data[ELEMENT_WIDTH*(NI-j)-1 -: ELEMENT_WIDTH];
         assign dp_second_row[ELEMENT_WIDTH*(NI-j)-1 -: ELEMENT_WIDTH] =
            pad ? '0 : y_rd_data[ELEMENT_WIDTH*(NI-j)-1 -: ELEMENT_WIDTH];
`else
         assign dp_first_row [ELEMENT_WIDTH*(NI-j)-1 -: ELEMENT_WIDTH] =
            x_rd_data[ELEMENT_WIDTH*(NI-j)-1 -: ELEMENT_WIDTH];
         assign dp_second_row[ELEMENT_WIDTH*(NI-j)-1 -: ELEMENT_WIDTH] =
            y_rd_data[ELEMENT_WIDTH*(NI-j)-1 -: ELEMENT_WIDTH];
`endif
      end
   endgenerate

   assign wr_en   = vld_pipe[PIPE_LATENCY];
   assign wr_addr = idx_pipe[PIPE_LATENCY];
   assign wr_data = dp_result;
   assign wr_mask = !vld_pipe[PIPE_LATENCY] ? '0 :
                    last_pipe[PIPE_LATENCY] ? LAST_MASK : {NI{1'b1}};

endmodule
